// File: rtl/axi_lite_sram_slave.sv
// AXI-lite slave in front of a word-addressed on-chip SRAM with a fixed response latency.
// Read and write channels are independent, each with one outstanding transaction.
module axi_lite_sram_slave #(
    parameter int                   BUS_WIDTH  = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   DEPTH      = 1024,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                   LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ar_valid,
    output logic                    ar_ready,
    input  logic [BUS_WIDTH-1:0]    ar_addr,
    input  logic [2:0]              ar_prot,
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [BUS_WIDTH-1:0]    aw_addr,
    input  logic [2:0]              aw_prot,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [1:0]              wr_breap
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAT_C = CW'(LATENCY);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_t;

    function automatic logic addr_in_range(input logic [BUS_WIDTH-1:0] addr);
        logic [BUS_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (off[BUS_WIDTH-1:AW+2] == '0);
    endfunction

    function automatic logic [AW-1:0] word_index(input logic [BUS_WIDTH-1:0] addr);
        logic [BUS_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return off[AW+1:2];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] byte_merge(input logic [DATA_WIDTH-1:0] old_word,
                                                         input logic [DATA_WIDTH-1:0] new_word,
                                                         input logic [SW-1:0]         strb);
        logic [DATA_WIDTH-1:0] merged;
        for (int i = 0; i < SW; i++) begin
            merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    r_state_t              r_state_r, r_next_s;
    w_state_t              w_state_r, w_next_s;
    logic [BUS_WIDTH-1:0]  ar_addr_r, aw_addr_r;
    logic [DATA_WIDTH-1:0] wdata_r, rd_data_r, rd_next_s, w_merge_s;
    logic [SW-1:0]         wstrb_r;
    logic [CW-1:0]         rd_cnt_r, wr_cnt_r;
    logic                  aw_got_r, w_got_r, rd_valid_r, wr_valid_r;
    logic [1:0]            wr_breap_r;
    logic                  ar_hs_s, aw_hs_s, w_hs_s, r_commit_s, w_commit_s;
    logic                  r_in_range_s, w_in_range_s;
    logic [AW-1:0]         r_word_s, w_word_s;
    logic                  unused_s;

    assign unused_s     = ^{ar_prot, aw_prot};
    assign ar_ready     = (r_state_r == R_IDLE);
    assign aw_ready     = (w_state_r == W_IDLE) && !aw_got_r;
    assign wd_ready     = (w_state_r == W_IDLE) && !w_got_r;
    assign ar_hs_s      = ar_valid && ar_ready;
    assign aw_hs_s      = aw_valid && aw_ready;
    assign w_hs_s       = wd_valid && wd_ready;
    assign r_in_range_s = addr_in_range(ar_addr_r);
    assign r_word_s     = word_index(ar_addr_r);
    assign w_in_range_s = addr_in_range(aw_addr_r);
    assign w_word_s     = word_index(aw_addr_r);
    assign w_merge_s    = byte_merge(mem_r[w_word_s], wdata_r, wstrb_r);
    assign rd_valid     = rd_valid_r;
    assign rd_data      = rd_data_r;
    assign wr_valid     = wr_valid_r;
    assign wr_breap     = wr_breap_r;

    // Read channel next-state and commit strobe
    always_comb begin
        r_next_s   = r_state_r;
        r_commit_s = 1'b0;
        case (r_state_r)
            R_IDLE: if (ar_hs_s) r_next_s = R_WAIT; else r_next_s = R_IDLE;
            R_WAIT: begin
                if (rd_cnt_r == LAT_C) begin
                    r_commit_s = 1'b1;
                    r_next_s   = R_RESP;
                end else begin
                    r_next_s = R_WAIT;
                end
            end
            R_RESP: if (rd_valid_r && rd_ready) r_next_s = R_IDLE; else r_next_s = R_RESP;
            default: r_next_s = R_IDLE;
        endcase
    end

    // Write channel next-state and commit strobe
    always_comb begin
        w_next_s   = w_state_r;
        w_commit_s = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if ((aw_got_r || aw_hs_s) && (w_got_r || w_hs_s)) w_next_s = W_WAIT;
                else w_next_s = W_IDLE;
            end
            W_WAIT: begin
                if (wr_cnt_r == LAT_C) begin
                    w_commit_s = 1'b1;
                    w_next_s   = W_RESP;
                end else begin
                    w_next_s = W_WAIT;
                end
            end
            W_RESP: if (wr_valid_r && wr_ready) w_next_s = W_IDLE; else w_next_s = W_RESP;
            default: w_next_s = W_IDLE;
        endcase
    end

    // Read data source: a write committing to the same word this edge wins
    always_comb begin
        rd_next_s = '0;
        if (!r_in_range_s) begin
            rd_next_s = '0;
        end else if (w_commit_s && w_in_range_s && (w_word_s == r_word_s)) begin
            rd_next_s = w_merge_s;
        end else begin
            rd_next_s = mem_r[r_word_s];
        end
    end

    // State registers for both channels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_r <= R_IDLE;
            w_state_r <= W_IDLE;
        end else begin
            r_state_r <= r_next_s;
            w_state_r <= w_next_s;
        end
    end

    // Read address latch, latency counter and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ar_addr_r  <= '0;
            rd_cnt_r   <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            if (ar_hs_s) ar_addr_r <= ar_addr;
            if (r_state_r == R_IDLE) rd_cnt_r <= ONE_C;
            else if (r_state_r == R_WAIT && !r_commit_s) rd_cnt_r <= rd_cnt_r + ONE_C;
            if (r_commit_s) begin
                rd_valid_r <= 1'b1;
                rd_data_r  <= rd_next_s;
            end else if (rd_valid_r && rd_ready) begin
                rd_valid_r <= 1'b0;
            end
        end
    end

    // AW/W latches, latency counter and registered write response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aw_got_r   <= 1'b0;
            w_got_r    <= 1'b0;
            aw_addr_r  <= '0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            wr_cnt_r   <= '0;
            wr_valid_r <= 1'b0;
            wr_breap_r <= 2'b00;
        end else begin
            if (aw_hs_s) begin
                aw_got_r  <= 1'b1;
                aw_addr_r <= aw_addr;
            end
            if (w_hs_s) begin
                w_got_r <= 1'b1;
                wdata_r <= wd_data;
                wstrb_r <= wstrb;
            end
            if (w_state_r == W_IDLE) wr_cnt_r <= ONE_C;
            else if (w_state_r == W_WAIT && !w_commit_s) wr_cnt_r <= wr_cnt_r + ONE_C;
            if (w_commit_s) begin
                wr_valid_r <= 1'b1;
                wr_breap_r <= w_in_range_s ? 2'b00 : 2'b10;
            end else if (wr_valid_r && wr_ready) begin
                wr_valid_r <= 1'b0;
                aw_got_r   <= 1'b0;
                w_got_r    <= 1'b0;
            end
        end
    end

    // SRAM array: contents survive reset, written only on an in-range commit
    always_ff @(posedge clk) begin
        if (w_commit_s && w_in_range_s) mem_r[w_word_s] <= w_merge_s;
    end
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Randomized self-checking bench for axi_lite_sram_slave against a word-array reference model.
module tb_axi_lite_sram_slave;
    localparam int               DEPTH  = 1024;
    localparam int               LAT    = 2;
    localparam logic [31:0]      BASE   = 32'h8000_0000;
    localparam longint unsigned  BASE_L = 64'h8000_0000;

    logic        clk, reset;
    logic        ar_valid, ar_ready, aw_valid, aw_ready;
    logic [31:0] ar_addr, aw_addr;
    logic [2:0]  ar_prot, aw_prot;
    logic        rd_valid, rd_ready, wd_valid, wd_ready, wr_valid, wr_ready;
    logic [31:0] rd_data, wd_data;
    logic [3:0]  wstrb;
    logic [1:0]  wr_breap;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [DEPTH];

    axi_lite_sram_slave #(.BUS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
                          .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_prot(ar_prot),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_prot(aw_prot),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wstrb(wstrb),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_breap(wr_breap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit in_rng(input logic [31:0] a);
        longint unsigned x = {32'h0000_0000, a};
        return (x >= BASE_L) && (x < BASE_L + DEPTH * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        longint unsigned x = {32'h0000_0000, a};
        return int'((x - BASE_L) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] m = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
        return m;
    endfunction

    task automatic read_txn(input logic [31:0] addr, input logic [31:0] exp, input int stall,
                            input string tag);
        int n, t, rise;
        bit bad;
        logic [31:0] d0;
        n = 0;
        @(negedge clk);
        ar_valid = 1'b1; ar_addr = addr; ar_prot = 3'($urandom);
        while (ar_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        t = cyc + 1;
        @(negedge clk);
        ar_valid = 1'b0; ar_addr = $urandom;
        rise = -1;
        for (int i = 0; i < 40; i++) begin
            if (rd_valid === 1'b1) begin rise = cyc; break; end
            @(negedge clk);
        end
        checks++;
        if (rise !== t + LAT) begin
            errors++; $display("FAIL %s rd_latency: got cycle %0d want %0d", tag, rise, t + LAT);
        end
        checks++;
        if (rd_data !== exp) begin
            errors++; $display("FAIL %s rd_data: got %h want %h", tag, rd_data, exp);
        end
        if (stall > 0) begin
            d0 = rd_data; bad = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                if (rd_valid !== 1'b1 || rd_data !== d0 || ar_ready !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s rd_stall_hold: got valid=%b data=%h ar_ready=%b want 1/%h/0",
                         tag, rd_valid, rd_data, ar_ready, d0);
            end
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || ar_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s rd_release: got valid=%b ar_ready=%b want 0/1", tag, rd_valid, ar_ready);
        end
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_start, input int w_start, input int stall, input string tag);
        int k, aw_e, w_e, t, rise;
        bit awp, wp, bad;
        logic [1:0] exp_resp;
        exp_resp = in_rng(addr) ? 2'b00 : 2'b10;
        awp = 1'b1; wp = 1'b1; k = 0; aw_e = 0; w_e = 0;
        while ((awp || wp) && k < 60) begin
            @(negedge clk);
            aw_valid = awp && (k >= aw_start); aw_addr = addr; aw_prot = 3'($urandom);
            wd_valid = wp && (k >= w_start); wd_data = data; wstrb = strb;
            if (aw_valid && aw_ready) begin awp = 1'b0; aw_e = cyc + 1; end
            if (wd_valid && wd_ready) begin wp = 1'b0; w_e = cyc + 1; end
            k++;
        end
        @(negedge clk);
        aw_valid = 1'b0; wd_valid = 1'b0; wd_data = $urandom; wstrb = 4'($urandom);
        t = (aw_e > w_e) ? aw_e : w_e;
        rise = -1;
        for (int i = 0; i < 40; i++) begin
            if (wr_valid === 1'b1) begin rise = cyc; break; end
            @(negedge clk);
        end
        checks++;
        if (awp || wp || rise !== t + LAT) begin
            errors++; $display("FAIL %s wr_latency: got cycle %0d want %0d", tag, rise, t + LAT);
        end
        checks++;
        if (wr_breap !== exp_resp) begin
            errors++; $display("FAIL %s wr_breap: got %b want %b", tag, wr_breap, exp_resp);
        end
        if (stall > 0) begin
            bad = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                if (wr_valid !== 1'b1 || wr_breap !== exp_resp) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++; $display("FAIL %s wr_stall_hold: got valid=%b want 1", tag, wr_valid);
            end
        end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        checks++;
        if (wr_valid !== 1'b0 || aw_ready !== 1'b1 || wd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s wr_release: got valid=%b aw_ready=%b wd_ready=%b want 0/1/1",
                     tag, wr_valid, aw_ready, wd_ready);
        end
        if (in_rng(addr)) model_mem[widx(addr)] = merge(model_mem[widx(addr)], data, strb);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({rd_valid, wr_valid, rd_data, wr_breap} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%b wv=%b rd=%h br=%b want all 0",
                     rd_valid, wr_valid, rd_data, wr_breap);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ar_ready, aw_ready, wd_ready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_readies: got %b want 111", {ar_ready, aw_ready, wd_ready});
        end
    endtask

    task automatic prefill;
        for (int w = 0; w < 64; w++) write_txn(BASE + 32'(w * 4), $urandom, 4'hF, 0, 0, 0, "prefill");
        write_txn(BASE + 32'h0000_0FFC, $urandom, 4'hF, 0, 0, 0, "prefill_last");
    endtask

    task automatic test_same_cycle;
        write_txn(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "same_cycle_wr");
        read_txn(32'h8000_0010, 32'hDEAD_BEEF, 0, "same_cycle_rd");
    endtask

    task automatic test_w_first;
        fork
            write_txn(32'h8000_0010, 32'h0000_00AA, 4'b0001, 3, 0, 0, "w_first_wr");
            begin
                repeat (3) @(negedge clk);
                checks++;
                if (aw_ready !== 1'b1 || wd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL w_first_readies: got aw=%b wd=%b want 1/0", aw_ready, wd_ready);
                end
            end
        join
        read_txn(32'h8000_0010, 32'hDEAD_BEAA, 0, "w_first_rd");
    endtask

    task automatic test_boundaries;
        read_txn(32'h7FFF_FFFC, 32'h0, 0, "oor_rd_low");
        write_txn(32'h8000_1000, $urandom, 4'hF, 0, 0, 0, "oor_wr_high");
        read_txn(BASE, model_mem[0], 0, "oor_no_alias");
        write_txn(32'h8000_0FFE, $urandom, 4'h0, 1, 0, 0, "strb_zero");
        read_txn(32'h8000_0FFF, model_mem[DEPTH-1], 0, "last_word_rd");
    endtask

    task automatic test_stall;
        fork
            read_txn(32'h8000_0004, model_mem[1], 5, "stall_rd");
            begin
                @(negedge clk);
                write_txn(32'h8000_000C, 32'h1234_5678, 4'hF, 0, 0, 2, "stall_wr");
            end
        join
        read_txn(32'h8000_000C, 32'h1234_5678, 0, "stall_wr_rd");
    endtask

    task automatic test_same_word_commit;
        logic [31:0] d, expd;
        d = $urandom;
        expd = merge(model_mem[8], d, 4'b0110);
        fork
            read_txn(32'h8000_0020, expd, 0, "commit_rd");
            write_txn(32'h8000_0020, d, 4'b0110, 0, 0, 0, "commit_wr");
        join
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        aw_valid = 1'b1; aw_addr = 32'h8000_0014; wd_valid = 1'b1;
        wd_data = ~model_mem[5]; wstrb = 4'hF;
        ar_valid = 1'b1; ar_addr = 32'h8000_0014;
        @(negedge clk);
        aw_valid = 1'b0; wd_valid = 1'b0; ar_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if ({rd_valid, wr_valid, ar_ready, aw_ready, wd_ready} !== 5'b00111) begin
            errors++;
            $display("FAIL reset_mid_state: got %b want 00111",
                     {rd_valid, wr_valid, ar_ready, aw_ready, wd_ready});
        end
        read_txn(32'h8000_0014, model_mem[5], 0, "reset_mid_rd");
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       a = BASE - 32'd4;
                    1:       a = BASE + 32'h0000_1000;
                    2:       a = 32'h0000_0000;
                    default: a = BASE + 32'h0000_1040;
                endcase
            end else begin
                a = BASE + 32'($urandom_range(0, 63) * 4);
            end
            a[1:0] = 2'($urandom);
            if ($urandom_range(0, 1) == 0)
                read_txn(a, in_rng(a) ? model_mem[widx(a)] : 32'h0, $urandom_range(0, 3), "rand_rd");
            else
                write_txn(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), "rand_wr");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 1'b0; reset = 1'b0;
        ar_valid = 1'b0; ar_addr = '0; ar_prot = '0;
        aw_valid = 1'b0; aw_addr = '0; aw_prot = '0;
        wd_valid = 1'b0; wd_data = '0; wstrb = '0;
        rd_ready = 1'b0; wr_ready = 1'b0;
        test_reset;
        prefill;
        test_same_cycle;
        test_w_first;
        test_boundaries;
        test_stall;
        test_same_word_commit;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
